line_memory_responder: RTL and testbench
========================================

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 Parameter LATENCY, default 4, meaning cycles from request sample edge to read data valid or write commit; legal range 1..15.
REQ-002 Parameter DEPTH_LINES, default 64, meaning number of 4-word lines stored; power of two, 4..1024.
REQ-003 Port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 Port readM, input, 1 bit, meaning line-read request, level held by the requester.
REQ-006 Port writeM, input, 1 bit, meaning line-write request, level held by the requester.
REQ-007 Port address, input, 16 bits, meaning word address; bits [1:0] are ignored and the line index is address[log2(DEPTH_LINES)+1:2]; higher bits alias.
REQ-008 Port data, inout, 64 bits, meaning line bus; word 0 is on [15:0] and word 3 is on [63:48].
REQ-009 Port ack, output, 1 bit, meaning a one-cycle completion pulse.
REQ-010 Port busy, output, 1 bit, meaning high in READ_WAIT and WRITE_WAIT.

Function
REQ-011 Storage SHALL be DEPTH_LINES x 64-bit lines.
REQ-012 The state machine SHALL have the states IDLE, READ_WAIT, READ_DRIVE, WRITE_WAIT and WRITE_DONE.
REQ-013 In IDLE, a sampled readM=1 SHALL latch the line index, clear the 4-bit counter and go to READ_WAIT.
REQ-014 In IDLE, readM=0 with writeM=1 SHALL latch the line index and go to WRITE_WAIT.
REQ-015 If readM=1 and writeM=1 are sampled together, the read SHALL win and the write SHALL be ignored.
REQ-016 In the WAIT states, the counter SHALL increment each cycle.
REQ-017 Address changes in the WAIT states SHALL be ignored, because the index is latched.
REQ-018 READ_WAIT: on the edge LATENCY cycles after the sample edge, the latched line SHALL be loaded into the output register, ack SHALL pulse for the following cycle, and the state SHALL become READ_DRIVE.
REQ-019 The data bus SHALL be driven only when state=READ_DRIVE and readM=1, and SHALL be high-Z otherwise.
REQ-020 READ_DRIVE: readM=0 SHALL return to IDLE.
REQ-021 READ_DRIVE: readM=1 with a different address[15:2] SHALL start a new read (READ_WAIT, counter cleared, new index latched) and tri-state the bus.
REQ-022 WRITE_WAIT: on the edge LATENCY cycles after the sample edge, the value on data at that edge SHALL be written to the latched line, ack SHALL pulse, and the state SHALL become WRITE_DONE.
REQ-023 WRITE_DONE: writeM=0 SHALL return to IDLE.
REQ-024 WRITE_DONE: writeM=1 with a different address[15:2] SHALL start a new write.
REQ-025 WRITE_DONE: writeM=1 with the same line SHALL NOT recommit.
REQ-026 A request withdrawn during a WAIT state (its strobe sampled 0) SHALL abort to IDLE with no ack and no storage change.
REQ-027 A read issued after a write completes SHALL return the written line.
REQ-028 The counter SHALL never wrap, because it is compared against LATENCY and cleared on every state entry.

Reset
REQ-029 Asserting reset at any time SHALL force IDLE, counter=0, ack=0, busy=0, the bus high-Z and the output register=0, with no clock required.
REQ-030 Reset during WRITE_WAIT SHALL NOT commit the write.
REQ-031 Reset SHALL NOT alter storage contents.
REQ-032 After reset deasserts, the first rising edge SHALL sample requests normally.

Configuration
REQ-033 With LINE_MEM_STATS_EN defined, the block SHALL add outputs rd_count[15:0] and wr_count[15:0], incremented on each read ack and write ack respectively, saturating at 16'hFFFF and cleared by reset.
REQ-034 Without LINE_MEM_STATS_EN, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Write then read: write line at address 0x0010 with data 0x4444_3333_2222_1111, hold writeM, then read at 0x0013 -> ack 4 cycles after each sample edge, and the read bus shows 0x4444_3333_2222_1111.
REQ-036 Collision: readM=1 and writeM=1 at 0x0020 -> read performed, storage at line 8 unchanged, exactly one ack.
REQ-037 Address-change restart: in READ_DRIVE at 0x0010, change the address to 0x0014 with readM held -> bus high-Z, then after 4 cycles it shows line 5 contents, with a second ack.
REQ-038 Abort: drop writeM after 2 cycles of WRITE_WAIT -> no ack, and a later read shows the old data.
REQ-039 Reset mid-write: assert reset at cycle 3 of WRITE_WAIT -> outputs at reset values immediately, line unchanged.
REQ-040 Stats with LINE_MEM_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; reset -> both 0.

Source files
------------

// File: rtl/line_memory_responder.sv
// line_memory_responder
//   Line-oriented memory responder. Holds DEPTH_LINES lines of four 16-bit
//   words and answers held-level read/write strobes after a fixed LATENCY.
//   A read drives the shared line bus only while in READ_DRIVE with readM
//   still high. A write captures the bus on the completion edge.
//
// Optional build feature:
//   LINE_MEM_STATS_EN adds saturating read/write acknowledge counters.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous active-high reset
//   readM     - line-read request (level)
//   writeM    - line-write request (level)
//   address   - word address; [1:0] ignored, line = address[log2(DEPTH)+1:2]
//   data      - bidirectional 64-bit line bus, word 0 on [15:0]
//   ack       - one-cycle completion pulse
//   busy      - high while waiting out the access latency
//   rd_count  - read acks seen, saturating   (LINE_MEM_STATS_EN only)
//   wr_count  - write acks seen, saturating  (LINE_MEM_STATS_EN only)
module line_memory_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  wire  [63:0] data,
  output logic        ack,
  output logic        busy
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int         IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE_WAIT,
    WRITE_DONE
  } state_t;

  state_t state, state_nxt;

  logic [63:0]      mem [DEPTH_LINES];
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [13:0]      addr_q;
  logic [63:0]      rd_line;

  logic latch_req;
  logic rd_load;
  logic wr_commit;
  logic addr_diff;
  logic wait_done;
  logic unused_addr_lsbs;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Word-select bits never reach the line store.
  assign unused_addr_lsbs = &{1'b0, address[1:0]};

  // "Different address" is judged on the full word-line address, so two
  // aliases of the same stored line still count as a new request.
  assign addr_diff = (address[15:2] != addr_q);

  // Counter is zero on the cycle after the sample edge, so the completion
  // edge is the one where it has reached LATENCY-1.
  assign wait_done = (cnt == LAST_CNT);

  assign busy = (state == READ_WAIT) || (state == WRITE_WAIT);

  assign data = (state == READ_DRIVE && readM) ? rd_line : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    case (state)
      IDLE: begin
        if (readM) begin
          latch_req = 1'b1;
          state_nxt = READ_WAIT;
        end else if (writeM) begin
          latch_req = 1'b1;
          state_nxt = WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        // A withdrawn strobe wins over completion on the same edge.
        if (!readM) begin
          state_nxt = IDLE;
        end else if (wait_done) begin
          rd_load   = 1'b1;
          state_nxt = READ_DRIVE;
        end
      end
      READ_DRIVE: begin
        if (!readM) begin
          state_nxt = IDLE;
        end else if (addr_diff) begin
          latch_req = 1'b1;
          state_nxt = READ_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (!writeM) begin
          state_nxt = IDLE;
        end else if (wait_done) begin
          wr_commit = 1'b1;
          state_nxt = WRITE_DONE;
        end
      end
      WRITE_DONE: begin
        if (!writeM) begin
          state_nxt = IDLE;
        end else if (addr_diff) begin
          latch_req = 1'b1;
          state_nxt = WRITE_WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      ack     <= 1'b0;
      rd_line <= '0;
    end else begin
      ack <= rd_load | wr_commit;
      // Cleared on every state change, so it can never pass LATENCY-1.
      if (state_nxt != state || !busy) cnt <= '0;
      else                             cnt <= cnt + 4'd1;
      if (rd_load) rd_line <= mem[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (latch_req) begin
      idx_q  <= address[IDX_W+1:2];
      addr_q <= address[15:2];
    end
    if (wr_commit) mem[idx_q] <= data;
  end

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_load)   rd_count <= sat_inc16(rd_count);
      if (wr_commit) wr_count <= sat_inc16(wr_count);
    end
  end
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// tb_line_memory_responder
//   Randomized transaction bench for line_memory_responder with a line-array
//   reference model. Inputs change 1 time unit after a rising edge and
//   outputs are compared at the same point.
module tb_line_memory_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 64;
  localparam int IDX_W = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [63:0] data;
  logic        ack;
  logic        busy;
  logic        drv_en;
  logic [63:0] drv_val;
`ifdef LINE_MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  // Bench side of the line bus; while the DUT must be high-Z the bench drives
  // a known probe value so any DUT drive shows up as a changed bus value.
  assign data = drv_en ? drv_val : 'z;

  line_memory_responder #(
    .LATENCY     (LAT),
    .DEPTH_LINES (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .readM    (readM),
    .writeM   (writeM),
    .address  (address),
    .data     (data),
    .ack      (ack),
    .busy     (busy)
`ifdef LINE_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          rd_n   = 0;
  int          wr_n   = 0;
  logic [63:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [IDX_W-1:0] lidx(input logic [15:0] a);
    return a[IDX_W+1:2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef LINE_MEM_STATS_EN
    check("rd_count", 64'(rd_count), 64'(rd_n));
    check("wr_count", 64'(wr_count), 64'(wr_n));
`endif
  endtask

  // abort_at = 0: full write; n in 1..LAT: writeM is seen low on edge S+n.
  // keep = 1 leaves writeM high in WRITE_DONE for a chained request.
  task automatic write_line(input logic [15:0] a, input logic [63:0] wd,
                            input int abort_at, input bit keep);
    writeM  = 1'b1;
    readM   = 1'b0;
    address = a;
    drv_en  = 1'b1;
    drv_val = wd;
    tick();
    check("wr_busy_s", 64'(busy), 64'd1);
    check("wr_ack_s", 64'(ack), 64'd0);
    for (int k = 1; k <= LAT; k++) begin
      if (k == abort_at) writeM = 1'b0;
      address = (k == LAT) ? a : 16'($urandom);
      tick();
      if (abort_at != 0 && k >= abort_at) begin
        check("abort_ack", 64'(ack), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
      end else if (k < LAT) begin
        check("wr_wait_ack", 64'(ack), 64'd0);
        check("wr_wait_busy", 64'(busy), 64'd1);
      end else begin
        check("wr_ack", 64'(ack), 64'd1);
        check("wr_done_busy", 64'(busy), 64'd0);
        model_mem[lidx(a)] = wd;
        wr_n++;
      end
    end
    address = a;
    if (abort_at == 0) begin
      // Same line held with new bus data must not commit again.
      drv_val = ~wd;
      tick();
      check("wr_hold_ack", 64'(ack), 64'd0);
      check("wr_hold_busy", 64'(busy), 64'd0);
    end
    drv_val = '0;
    if (!keep || abort_at != 0) begin
      writeM = 1'b0;
      tick();
      check("wr_idle_ack", 64'(ack), 64'd0);
      check("wr_idle_busy", 64'(busy), 64'd0);
    end
  endtask

  // collide = 1 raises writeM together with readM and drives a decoy value
  // on the bus during the wait; keep = 1 leaves the read held in READ_DRIVE.
  task automatic read_line(input logic [15:0] a, input bit collide, input bit keep);
    logic [63:0] exp;
    logic [63:0] probe;
    probe   = collide ? {$urandom, $urandom} : 64'd0;
    readM   = 1'b1;
    writeM  = collide;
    address = a;
    if (collide) begin
      drv_en  = 1'b1;
      drv_val = probe;
    end
    tick();
    drv_en  = 1'b1;
    drv_val = probe;
    check("rd_busy_s", 64'(busy), 64'd1);
    check("rd_ack_s", 64'(ack), 64'd0);
    check("rd_hiz_s", data, probe);
    for (int k = 1; k <= LAT; k++) begin
      address = (k == LAT) ? a : 16'($urandom);
      if (k == LAT) drv_en = 1'b0;
      tick();
      if (k < LAT) begin
        check("rd_wait_ack", 64'(ack), 64'd0);
        check("rd_wait_busy", 64'(busy), 64'd1);
        check("rd_wait_hiz", data, probe);
      end else begin
        exp = model_mem[lidx(a)];
        check("rd_ack", 64'(ack), 64'd1);
        check("rd_drive_busy", 64'(busy), 64'd0);
        check("rd_data", data, exp);
        rd_n++;
      end
    end
    tick();
    check("rd_hold_ack", 64'(ack), 64'd0);
    check("rd_hold_data", data, model_mem[lidx(a)]);
    if (!keep) begin
      readM   = 1'b0;
      writeM  = 1'b0;
      drv_en  = 1'b1;
      drv_val = '0;
      #1;
      check("rd_release_hiz", data, 64'd0);
      tick();
      check("rd_idle_ack", 64'(ack), 64'd0);
      check("rd_idle_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] a2;
    logic [63:0] old;
    int          op;

    reset   = 1'b1;
    readM   = 1'b0;
    writeM  = 1'b0;
    address = '0;
    drv_en  = 1'b1;
    drv_val = '0;
    #2;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hiz", data, 64'd0);
    check_stats();
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) write_line(16'(i * 4), {$urandom, $urandom}, 0, 0);

    // Write then read with word offset ignored.
    write_line(16'h0010, 64'h4444_3333_2222_1111, 0, 0);
    tick();
    read_line(16'h0013, 0, 0);
    check("wr_rd_line4", model_mem[4], 64'h4444_3333_2222_1111);

    // Simultaneous strobes: read wins, line 8 untouched.
    old = model_mem[8];
    read_line(16'h0020, 1, 0);
    read_line(16'h0020, 0, 0);
    check("collide_model", model_mem[8], old);

    // Address change while driving restarts the read.
    read_line(16'h0010, 0, 1);
    read_line(16'h0014, 0, 0);

    // Withdrawn write leaves the old data.
    write_line(16'h0018, {$urandom, $urandom}, 2, 0);
    read_line(16'h0018, 0, 0);

    // Reset during the last wait cycle of a write.
    a      = 16'h0030;
    writeM = 1'b1;
    address = a;
    drv_val = ~model_mem[lidx(a)];
    tick();
    tick();
    tick();
    tick();
    #1;
    reset   = 1'b1;
    drv_val = '0;
    rd_n    = 0;
    wr_n    = 0;
    #1;
    check("rstw_ack", 64'(ack), 64'd0);
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_hiz", data, 64'd0);
    check_stats();
    tick();
    check("rstw_busy_edge", 64'(busy), 64'd0);
    writeM = 1'b0;
    reset  = 1'b0;
    read_line(a, 0, 0);
    write_line(16'h0044, {$urandom, $urandom}, 0, 0);
    read_line(16'h0044, 0, 0);
    write_line(16'h0048, {$urandom, $urandom}, 0, 0);
    read_line(16'h0048, 0, 0);
    check_stats();

    for (int n = 0; n < 60; n++) begin
      a  = 16'($urandom);
      a2 = a + 16'(4 * $urandom_range(1, 100));
      op = $urandom_range(0, 5);
      case (op)
        0: write_line(a, {$urandom, $urandom}, 0, 0);
        1: write_line(a, {$urandom, $urandom}, $urandom_range(1, LAT), 0);
        2: read_line(a, 0, 0);
        3: read_line(a, 1, 0);
        4: begin
          write_line(a, {$urandom, $urandom}, 0, 1);
          write_line(a2, {$urandom, $urandom}, 0, 0);
        end
        default: begin
          read_line(a, 0, 1);
          read_line(a2, 0, 0);
        end
      endcase
    end
    for (int i = 0; i < 8; i++) read_line(16'($urandom), 0, 0);
    check_stats();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
